tx_core_mux: RTL
================

TX_CORE_MUX -- requirements
Module: tx_core_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of ADC source channels (1..16).
REQ-002 SHALL have parameter SPC, default 8: samples per clock per channel.
REQ-003 SHALL have parameter SAMPLE_W, default 16: signed two's-complement sample width.
REQ-004 SHALL have parameter MUTE_CYCLES, default 4: zero-output cycles inserted on a source switch (>=1).
REQ-005 SHALL have parameter TONE_AMP, default 16'h4000: tone amplitude, positive, < 2^(SAMPLE_W-1).
REQ-006 SHALL have port clock, input, 1: sole clock; all logic rising-edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port output_select, input, 5: requested source code.
REQ-009 SHALL have port lo_dds_phase_inc, input, 16: tone phase increment per sample.
REQ-010 SHALL have port adc_data, input, NUM_CH*SPC*SAMPLE_W: channel c occupies slice c*SPC*SAMPLE_W upward; lane 0 at the LSBs is the earliest sample.
REQ-011 SHALL have port dac_data, output, SPC*SAMPLE_W: output samples, same lane order.
REQ-012 SHALL have port active_select, output, 5: source code currently driving dac_data.
REQ-013 SHALL have port switching, output, 1: high while in MUTE state.

Function
REQ-014 Source codes SHALL be: 0 = zeros; 1..NUM_CH = adc channel (code-1) passthrough; NUM_CH+1 = square tone; NUM_CH+2 = ramp; any other code = zeros, and it SHALL still be reported in active_select.
REQ-015 Latency SHALL be exactly 2 cycles from adc_data to dac_data (one input register stage, one output register stage).
REQ-016 Phase accumulator: 16-bit acc; lane k phase = acc + k*inc (mod 2^16); acc += SPC*inc each cycle, wrapping mod 2^16.
REQ-017 Tone lane k SHALL be +TONE_AMP when phase bit 15 = 0, and -TONE_AMP when it is 1, sign-extended to SAMPLE_W.
REQ-018 A change on lo_dds_phase_inc SHALL take effect on the next accumulator update without resetting acc.
REQ-019 Ramp: 16-bit counter cnt; lane k = (cnt*SPC + k) mod 2^SAMPLE_W; cnt increments every cycle and wraps.
REQ-020 The accumulator and ramp counter SHALL run continuously regardless of the selected source.
REQ-021 FSM states SHALL be RUN and MUTE.
REQ-022 RUN: when output_select != active_select, latch pending = output_select, load mute counter with MUTE_CYCLES-1, and go to MUTE.
REQ-023 MUTE: dac_data input stage forced to zero; if output_select != pending, re-latch pending and reload the counter; otherwise, when the counter = 0, set active_select = pending and go to RUN; else decrement.
REQ-024 Consequently, a single select change SHALL produce exactly MUTE_CYCLES zero output words, then the new source with no partial word.
REQ-025 switching SHALL be high for every cycle the FSM is in MUTE, and SHALL be registered (not combinational on output_select).

Reset
REQ-026 On resetn low, the block SHALL asynchronously clear dac_data, acc, cnt, pending and the mute counter to 0, set active_select = 0, set switching = 0, and set the state to RUN.
REQ-027 Reset asserted mid-MUTE SHALL abandon the pending switch; after release, a nonzero output_select SHALL start a fresh MUTE sequence.
REQ-028 After release, the first acc/cnt update SHALL occur on the first rising edge with resetn high.

Verification
REQ-029 Reset release with output_select=1 and channel 0 lanes = 1..8 -> switching high for 4 cycles, zeros out, then dac_data lanes = 1..8 with 2-cycle latency, active_select=1.
REQ-030 Tone: select=NUM_CH+1, inc=16'h1000 -> lanes 0..7 = +16'h4000, next word lanes = -16'h4000 (16'hC000), period 16 samples.
REQ-031 Ramp: select=NUM_CH+2 -> consecutive words 0..7, 8..15, ...; the counter wraps to 0 after 65535.
REQ-032 Select toggled 1->2->3 on consecutive cycles during MUTE -> one MUTE sequence of 4 zero words after the last change, then channel 2 data.
REQ-033 Select=31 (invalid) -> zero output after the mute, active_select=31; then changing inc mid-tone -> the phase continues from the current acc without a jump.
REQ-034 Asserting resetn low during MUTE count 2 -> all outputs 0 immediately; the pending select is not applied after release until re-detected.

Source files
------------

// File: rtl/tx_core_mux.sv
// TX core source multiplexer: selects zeros, an ADC channel, a square tone or a ramp
// for the DAC. A source change inserts MUTE_CYCLES all-zero words so the DAC never sees
// a partial word. Pipeline: input register stage, then output register stage.
module tx_core_mux #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned SPC         = 8,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned MUTE_CYCLES = 4,
  parameter int unsigned TONE_AMP    = 16'h4000
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [4:0]                       output_select,
  input  logic [15:0]                      lo_dds_phase_inc,
  input  logic [NUM_CH*SPC*SAMPLE_W-1:0]   adc_data,
  output logic [SPC*SAMPLE_W-1:0]          dac_data,
  output logic [4:0]                       active_select,
  output logic                             switching
);

  localparam int unsigned WordW = SPC * SAMPLE_W;
  localparam int unsigned CntW  = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [SAMPLE_W-1:0] TonePos = SAMPLE_W'(TONE_AMP);
  localparam logic [SAMPLE_W-1:0] ToneNeg = ~TonePos + 1'b1;

  typedef enum logic [0:0] {StRun, StMute} state_e;

  state_e            state_q;
  logic [4:0]        pending_q;
  logic [CntW-1:0]   mute_cnt_q;
  logic [15:0]       acc_q;
  logic [15:0]       cnt_q;
  logic [WordW-1:0]  stage_q;

  logic [SPC-1:0]    tone_neg;
  logic [WordW-1:0]  tone_word;
  logic [WordW-1:0]  ramp_word;
  logic [WordW-1:0]  src_word;

  // Per-lane tone and ramp samples from the free-running accumulator and counter.
  always_comb begin
    tone_neg  = '0;
    tone_word = '0;
    ramp_word = '0;
    for (int k = 0; k < SPC; k++) begin
      // Phase MSB set means the negative half of the square wave.
      tone_neg[k] = (acc_q + 16'(k) * lo_dds_phase_inc) >= 16'h8000;
      tone_word[k*SAMPLE_W +: SAMPLE_W] = tone_neg[k] ? ToneNeg : TonePos;
      ramp_word[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(32'(cnt_q) * 32'(SPC) + 32'(k));
    end
  end

  // Source selection for the input stage; MUTE and unknown codes give zeros.
  always_comb begin
    src_word = '0;
    if (state_q == StRun) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (active_select == 5'(c + 1)) src_word = adc_data[c*WordW +: WordW];
      end
      if (active_select == 5'(NUM_CH + 1)) src_word = tone_word;
      if (active_select == 5'(NUM_CH + 2)) src_word = ramp_word;
    end
  end

  // Datapath: two register stages plus the always-running phase accumulator and ramp counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      dac_data <= '0;
    end else begin
      acc_q    <= acc_q + 16'(SPC) * lo_dds_phase_inc;
      cnt_q    <= cnt_q + 16'd1;
      stage_q  <= src_word;
      dac_data <= stage_q;
    end
  end

  // Switch FSM: any select change (re)starts a full mute before the new source is applied.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StRun;
      pending_q     <= '0;
      mute_cnt_q    <= '0;
      active_select <= '0;
      switching     <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (output_select != active_select) begin
            pending_q  <= output_select;
            mute_cnt_q <= CntW'(MUTE_CYCLES - 1);
            state_q    <= StMute;
            switching  <= 1'b1;
          end
        end
        StMute: begin
          if (output_select != pending_q) begin
            pending_q  <= output_select;
            mute_cnt_q <= CntW'(MUTE_CYCLES - 1);
          end else if (mute_cnt_q == '0) begin
            active_select <= pending_q;
            state_q       <= StRun;
            switching     <= 1'b0;
          end else begin
            mute_cnt_q <= mute_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= StRun;
          switching <= 1'b0;
        end
      endcase
    end
  end

endmodule
